// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive parity sweep checker around a combinational Skolem block
module skolem_sweep_checker #(
  parameter int NX            = 6,
  parameter int NY            = 10,
  parameter int TARGET_PARITY = 1,
  parameter int SETTLE        = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [NX-1:0] x_out,
  input  logic [NY-1:0] y_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NX:0]   fail_count,
  output logic [NX-1:0] first_fail_x,
  output logic          first_fail_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int            SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] CNT_LAST = SW'(SETTLE - 1);
  localparam logic [NX-1:0] X_LAST   = {NX{1'b1}};
  localparam logic [NX:0]   FAIL_MAX = {1'b1, {NX{1'b0}}};
  localparam logic          TP       = 1'(TARGET_PARITY);

  logic [1:0]    state;
  logic [SW-1:0] settle_cnt;
  logic          parity;
  logic          mismatch;
  logic [NX:0]   fail_nxt;

  // Parity check of the current pair and the saturating next failure count
  always_comb begin
    parity   = ^{y_in, x_out};
    mismatch = (state == S_CHECK) && (parity != TP);
    fail_nxt = fail_count;
    if (mismatch && (fail_count != FAIL_MAX)) begin
      fail_nxt = fail_count + {{NX{1'b0}}, 1'b1};
    end
  end

  // Status decoded straight from the state register
  always_comb begin
    busy = (state == S_DRIVE) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  // Sweep sequencer: drive x, wait SETTLE cycles, check once, advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      settle_cnt       <= '0;
      x_out            <= '0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_x     <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_DRIVE;
            settle_cnt       <= '0;
            x_out            <= '0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_x     <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (settle_cnt == CNT_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          fail_count <= fail_nxt;
          if (mismatch && !first_fail_valid) begin
            first_fail_x     <= x_out;
            first_fail_valid <= 1'b1;
          end
          if (x_out == X_LAST) begin
            // Verdict uses the count including this last check
            state <= S_DONE;
            pass  <= (fail_nxt == '0);
          end else begin
            x_out      <= x_out + 1'b1;
            settle_cnt <= '0;
            state      <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - scoreboard bench for skolem_sweep_checker
module tb_skolem_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  int         mode = 0;

  logic [5:0] x_a, x_b, ffx_a, ffx_b, xd1, xd2;
  logic [9:0] y_a, y_b;
  logic       busy_a, done_a, pass_a, ffv_a;
  logic       busy_b, done_b, pass_b, ffv_b;
  logic [6:0] fc_a, fc_b;

  int total = 0;
  int bad = 0;
  int done_cnt_a = 0;

  typedef struct {
    logic       pass;
    logic [6:0] cnt;
    logic [5:0] ffx;
    logic       ffv;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  skolem_sweep_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x_out(x_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
    .first_fail_x(ffx_a), .first_fail_valid(ffv_a)
  );

  skolem_sweep_checker #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x_out(x_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
    .first_fail_x(ffx_b), .first_fail_valid(ffv_b)
  );

  // Skolem model: bit 7 fixed high, bit 0 fixes overall parity to 1
  function automatic logic [9:0] ymodel(input logic [5:0] x, input int m);
    logic [8:0] hi;
    logic       p0;
    hi = 9'b001000000;
    p0 = 1'b1 ^ (^x) ^ (^hi);
    case (m)
      0:       ymodel = {hi, p0};
      1:       ymodel = (x == 6'd37) ? {hi, ~p0} : {hi, p0};
      2:       ymodel = {hi, ~p0};
      default: ymodel = 10'd0;
    endcase
  endfunction

  assign y_a = ymodel(x_a, mode);

  always @(posedge clk) begin
    xd1 <= x_b;
    xd2 <= xd1;
  end
  assign y_b = ymodel(xd2, 0);

  always @(negedge clk) if (done_a) done_cnt_a++;

  task automatic run_sweep(input bit use_b, input bit inject, output int lat,
                           output int seq_err, output logic first_busy,
                           output logic [5:0] first_x);
    int n;
    logic [5:0] prev, cx;
    bit inj;
    inj = 0;
    seq_err = 0;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    n = 1;
    first_busy = use_b ? busy_b : busy_a;
    first_x = use_b ? x_b : x_a;
    prev = first_x;
    while (!(use_b ? done_b : done_a) && n < 2000) begin
      if (inject && x_a == 6'd5 && !inj) begin
        start_a = 1'b1;
        inj = 1;
      end
      @(negedge clk);
      n++;
      start_a = 1'b0;
      cx = use_b ? x_b : x_a;
      if (cx != prev && cx != prev + 6'd1) seq_err++;
      prev = cx;
    end
    lat = (n >= 2000) ? -1 : n;
  endtask

  task automatic check_result(input string name, input bit use_b, input int lat);
    exp_t e;
    logic p, v;
    logic [6:0] c;
    logic [5:0] f;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    p = use_b ? pass_b : pass_a;
    c = use_b ? fc_b : fc_a;
    f = use_b ? ffx_b : ffx_a;
    v = use_b ? ffv_b : ffv_a;
    total++; if (lat !== e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat); end
    total++; if (p !== e.pass) begin bad++; $display("FAIL %s pass got=%b want=%b", name, p, e.pass); end
    total++; if (c !== e.cnt) begin bad++; $display("FAIL %s fail_count got=%0d want=%0d", name, c, e.cnt); end
    total++; if (v !== e.ffv) begin bad++; $display("FAIL %s first_fail_valid got=%b want=%b", name, v, e.ffv); end
    total++; if (f !== e.ffx) begin bad++; $display("FAIL %s first_fail_x got=%0d want=%0d", name, f, e.ffx); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({x_a, busy_a, done_a, pass_a, fc_a, ffx_a, ffv_a} !== 23'd0) begin
      bad++; $display("FAIL reset_a got=%h want=0", {x_a, busy_a, done_a, pass_a, fc_a, ffx_a, ffv_a});
    end
    total++; if ({x_b, busy_b, done_b, pass_b, fc_b, ffx_b, ffv_b} !== 23'd0) begin
      bad++; $display("FAIL reset_b got=%h want=0", {x_b, busy_b, done_b, pass_b, fc_b, ffx_b, ffv_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep(input string name, input int m, input logic ep,
                            input logic [6:0] ec, input logic [5:0] ef, input logic ev);
    int lat, se;
    logic fb;
    logic [5:0] fx;
    mode = m;
    sb.push_back('{pass: ep, cnt: ec, ffx: ef, ffv: ev, lat: 129});
    run_sweep(0, 0, lat, se, fb, fx);
    total++; if (fb !== 1'b1 || fx !== 6'd0) begin
      bad++; $display("FAIL %s first_cycle busy=%b x=%0d want busy=1 x=0", name, fb, fx);
    end
    check_result(name, 0, lat);
    @(negedge clk);
    total++; if (done_a !== 1'b0 || busy_a !== 1'b0 || pass_a !== ep || fc_a !== ec) begin
      bad++; $display("FAIL %s hold done=%b busy=%b pass=%b cnt=%0d want done=0 busy=0 pass=%b cnt=%0d",
                      name, done_a, busy_a, pass_a, fc_a, ep, ec);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 3;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (x_a != 6'd20 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++; if (x_a !== 6'd20 || fc_a === 7'd0) begin
      bad++; $display("FAIL reset_mid reach x=%0d cnt=%0d want x=20 cnt>0", x_a, fc_a);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({x_a, busy_a, done_a, pass_a, fc_a, ffx_a, ffv_a} !== 23'd0) begin
      bad++; $display("FAIL reset_mid outputs got=%h want=0", {x_a, busy_a, done_a, pass_a, fc_a, ffx_a, ffv_a});
    end
    rst = 1'b0;
    test_sweep("after_reset", 0, 1'b1, 7'd0, 6'd0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int lat, se, d0;
    logic fb;
    logic [5:0] fx;
    mode = 0;
    d0 = done_cnt_a;
    sb.push_back('{pass: 1'b1, cnt: 7'd0, ffx: 6'd0, ffv: 1'b0, lat: 129});
    run_sweep(0, 1, lat, se, fb, fx);
    check_result("start_busy", 0, lat);
    total++; if (se !== 0 || x_a !== 6'd63 || fx !== 6'd0) begin
      bad++; $display("FAIL start_busy sequence errs=%0d last_x=%0d first_x=%0d want 0/63/0", se, x_a, fx);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    total++; if (busy_a !== 1'b0) begin
      bad++; $display("FAIL start_in_done busy got=%b want=0", busy_a);
    end
    repeat (300) @(negedge clk);
    total++; if (done_cnt_a - d0 !== 1 || busy_a !== 1'b0) begin
      bad++; $display("FAIL start_busy done_pulses got=%0d want=1 busy=%b", done_cnt_a - d0, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int lat, se;
    logic fb;
    logic [5:0] fx;
    mode = 1;
    sb.push_back('{pass: 1'b0, cnt: 7'd1, ffx: 6'd37, ffv: 1'b1, lat: 129});
    run_sweep(0, 0, lat, se, fb, fx);
    check_result("b2b_first", 0, lat);
    mode = 0;
    sb.push_back('{pass: 1'b1, cnt: 7'd0, ffx: 6'd0, ffv: 1'b0, lat: 129});
    run_sweep(0, 0, lat, se, fb, fx);
    check_result("b2b_second", 0, lat);
  endtask

  task automatic test_settle3();
    int lat, se;
    logic fb;
    logic [5:0] fx;
    sb.push_back('{pass: 1'b1, cnt: 7'd0, ffx: 6'd0, ffv: 1'b0, lat: 257});
    run_sweep(1, 0, lat, se, fb, fx);
    check_result("settle3", 1, lat);
    total++; if (se !== 0 || x_b !== 6'd63) begin
      bad++; $display("FAIL settle3 sequence errs=%0d last_x=%0d want 0/63", se, x_b);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("correct", 0, 1'b1, 7'd0, 6'd0, 1'b0);
    test_sweep("single_fault", 1, 1'b0, 7'd1, 6'd37, 1'b1);
    test_sweep("all_wrong", 2, 1'b0, 7'd64, 6'd0, 1'b1);
    test_sweep("y_zero", 3, 1'b0, 7'd32, 6'd0, 1'b1);
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_settle3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
